// File: rtl/bnn_xnor_layer.sv
// Binary fully-connected layer: streams DEPTH weight words, XNOR-popcounts each against
// the latched input vector over a two-stage pipeline and thresholds into one bit per neuron.
module bnn_xnor_layer #(
    parameter int N      = 8,
    parameter int DEPTH  = 16,
    parameter int THRESH = N / 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             weights_ready,
    input  logic             start,
    input  logic [N-1:0]     act_in,
    output logic [AW-1:0]    weight_addr,
    input  logic [N-1:0]     weight_data,
    output logic             busy,
    output logic             pc_valid,
    output logic [PW-1:0]    pc_out,
    output logic [AW-1:0]    pc_idx,
    output logic [DEPTH-1:0] act_out,
    output logic             done,
    output logic             abort
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [PW-1:0] THR  = PW'(THRESH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;

    logic [N-1:0]  act_reg;
    logic [N-1:0]  xnor_reg;
    logic [AW-1:0] idx1;
    logic          v1;
    logic [PW-1:0] pc;
    logic          abort_now;

    always_comb begin
        pc = '0;
        for (int i = 0; i < N; i++) pc = pc + PW'(xnor_reg[i]);
    end

    assign abort_now = (state != IDLE) && !weights_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            act_reg     <= '0;
            xnor_reg    <= '0;
            idx1        <= '0;
            v1          <= 1'b0;
            weight_addr <= '0;
            busy        <= 1'b0;
            pc_valid    <= 1'b0;
            pc_out      <= '0;
            pc_idx      <= '0;
            act_out     <= '0;
            done        <= 1'b0;
            abort       <= 1'b0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            // The neuron sitting in stage 1 when the run aborts is dropped, not reported.
            if (v1 && !abort_now) begin
                act_out[idx1] <= (pc >= THR);
                pc_out        <= pc;
                pc_idx        <= idx1;
                pc_valid      <= 1'b1;
            end else begin
                pc_valid <= 1'b0;
            end
            if (abort_now) begin
                abort       <= 1'b1;
                busy        <= 1'b0;
                v1          <= 1'b0;
                weight_addr <= '0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start && weights_ready) begin
                        act_reg     <= act_in;
                        weight_addr <= '0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                    RUN: begin
                        xnor_reg <= ~(weight_data ^ act_reg);
                        idx1     <= weight_addr;
                        v1       <= 1'b1;
                        if (weight_addr == LAST) begin
                            weight_addr <= '0;
                            state       <= DRAIN;
                        end else begin
                            weight_addr <= weight_addr + AW'(1);
                        end
                    end
                    DRAIN: begin
                        v1    <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bnn_xnor_layer.sv
// Directed bench for bnn_xnor_layer: full runs, ignored starts, abort, back-to-back, async reset.
module tb_bnn_xnor_layer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        weights_ready;
    logic        start;
    logic [7:0]  act_in;
    logic [3:0]  weight_addr;
    logic [7:0]  weight_data;
    logic        busy, pc_valid, done, abort;
    logic [3:0]  pc_out;
    logic [3:0]  pc_idx;
    logic [15:0] act_out;
    logic [7:0]  mem [16];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign weight_data = mem[weight_addr];

    bnn_xnor_layer dut (
        .clk(clk), .rst_n(rst_n), .weights_ready(weights_ready), .start(start),
        .act_in(act_in), .weight_addr(weight_addr), .weight_data(weight_data),
        .busy(busy), .pc_valid(pc_valid), .pc_out(pc_out), .pc_idx(pc_idx),
        .act_out(act_out), .done(done), .abort(abort)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pc_model(input logic [7:0] w, input logic [7:0] a);
        logic [7:0] x;
        logic [3:0] n;
        x = ~(w ^ a);
        n = 0;
        for (int i = 0; i < 8; i++) n += {3'b0, x[i]};
        return n;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, weight_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pcv"}, pc_valid, 0);
        chk({tag, "_pco"}, pc_out, 0);
        chk({tag, "_pci"}, pc_idx, 0);
        chk({tag, "_act"}, act_out, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_abort"}, abort, 0);
    endtask

    // Pulses start, then checks every cycle through done; caller is between edges.
    task automatic run_layer(input string tag, input logic [7:0] a, input logic [15:0] exp_act);
        start = 1; act_in = a;
        @(posedge clk); #1 start = 0;
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            chk({tag, "_addr"}, weight_addr, (c <= 15) ? c : 0);
            chk({tag, "_busy"}, busy, c <= 16);
            chk({tag, "_done"}, done, c == 17);
            chk({tag, "_pcv"}, pc_valid, c >= 2);
            if (c >= 2) begin
                chk({tag, "_idx"}, pc_idx, c - 2);
                chk({tag, "_pc"}, pc_out, pc_model(mem[c-2], a));
            end
        end
        chk({tag, "_actout"}, act_out, exp_act);
    endtask

    initial begin
        rst_n = 0; start = 0; act_in = 0; weights_ready = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'hFF;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom); act_in = 8'($urandom); weights_ready = 1'($urandom);
        end
        @(negedge clk);
        chk_zero("rst");
        start = 0; weights_ready = 0;
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("rst_rel_busy", busy, 0);
        chk("rst_rel_addr", weight_addr, 0);

        // All ones -> popcount 8 everywhere
        weights_ready = 1;
        run_layer("ones", 8'hFF, 16'hFFFF);

        // weight_mem[i] = i, act F0 -> pc = 4 - popcount(i)
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        @(negedge clk);
        run_layer("ramp", 8'hF0, 16'h0001);
        chk("ramp_pc5_hand", pc_model(mem[5], 8'hF0), 2);

        // Start without weights_ready is ignored
        @(negedge clk);
        weights_ready = 0; start = 1; act_in = 8'h0F;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("nrdy_busy", busy, 0);
            chk("nrdy_pcv", pc_valid, 0);
            chk("nrdy_done", done, 0);
        end
        start = 0; weights_ready = 1;
        @(negedge clk);
        run_layer("ramp0f", 8'h0F, 16'hFFFF);

        // Abort: weights_ready sampled low at T+5
        @(negedge clk);
        start = 1; act_in = 8'hF0;
        @(posedge clk); #1 start = 0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            chk("abt_done", done, 0);
            chk("abt_pcv", pc_valid, (c >= 2) && (c <= 4));
            if (c >= 2 && c <= 4) chk("abt_idx", pc_idx, c - 2);
            chk("abt_abort", abort, c == 5);
            if (c == 5) begin
                chk("abt_busy", busy, 0);
                chk("abt_addr", weight_addr, 0);
            end
            if (c == 4) weights_ready = 0;
            if (c == 6) weights_ready = 1;
        end
        chk("abt_actout", act_out, 16'hFFF9);

        // Start held high through done -> back-to-back run at T+18
        start = 1; act_in = 8'hF0;
        @(posedge clk); #1;
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            chk("b2b1_done", done, c == 17);
            chk("b2b1_busy", busy, c <= 16);
        end
        chk("b2b1_actout", act_out, 16'h0001);
        act_in = 8'h0F;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("b2b2_busy", busy, 1);
        chk("b2b2_addr", weight_addr, 0);
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); @(negedge clk);
            chk("b2b2_done", done, c == 17);
        end
        chk("b2b2_actout", act_out, 16'hFFFF);

        // Asynchronous reset mid-run
        start = 1; act_in = 8'hFF;
        @(posedge clk); #1 start = 0;
        repeat (8) @(posedge clk);
        #2 rst_n = 0;
        #1 chk_zero("arst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("arst_done", done, 0);
            chk("arst_busy", busy, 0);
        end
        run_layer("fresh", 8'hFF, 16'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
